// File: rtl/c2_sm_serial_decoder.sv
// Bit-serial two's complement to sign-magnitude decoder.
// Recovers |x| LSB first by copying digits up to the first 1 and inverting the rest.
module c2_sm_serial_decoder #(
  parameter int unsigned N = 8
) (
  input  logic         clock,
  input  logic         reset,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [N-1:0] x,
  output logic         out_valid,
  input  logic         out_ready,
  output logic         sign,
  output logic [N-2:0] mag,
  output logic         ow
);

  localparam int unsigned W  = N - 1;
  localparam int unsigned CW = (N > 2) ? $clog2(N) : 1;
  localparam logic [CW-1:0] LAST_COUNT = CW'(N - 2);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_t;

  state_t          state_q, state_d;
  logic [W-1:0]    sr_q, sr_d;
  logic [W-1:0]    mag_q, mag_d;
  logic [CW-1:0]   count_q, count_d;
  logic            sign_q, sign_d;
  logic            seen_one_q, seen_one_d;
  logic            ow_q, ow_d;
  logic            accept_c;
  logic            last_digit_c;
  logic            digit_c;

  assign accept_c     = (state_q == IDLE) && in_valid;
  assign last_digit_c = (state_q == SHIFT) && (count_q == LAST_COUNT);
  // Invert only once a 1 has been passed, and only for negative operands.
  assign digit_c      = (sign_q && seen_one_q) ? ~sr_q[0] : sr_q[0];

  // State register
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (in_valid)     state_d = SHIFT;
      SHIFT:   if (last_digit_c) state_d = DONE;
      DONE:    if (out_ready)    state_d = IDLE;
      default:                   state_d = IDLE;
    endcase
  end

  // Handshake outputs decoded from registered state
  always_comb begin
    in_ready  = 1'b0;
    out_valid = 1'b0;
    case (state_q)
      IDLE:    in_ready  = 1'b1;
      DONE:    out_valid = 1'b1;
      default: ;
    endcase
  end

  // Datapath next-state: load on accept, one digit per SHIFT edge
  always_comb begin
    sr_d       = sr_q;
    mag_d      = mag_q;
    count_d    = count_q;
    sign_d     = sign_q;
    seen_one_d = seen_one_q;
    ow_d       = ow_q;
    if (accept_c) begin
      sr_d       = x[N-2:0];
      sign_d     = x[N-1];
      seen_one_d = 1'b0;
      count_d    = '0;
    end else if (state_q == SHIFT) begin
      mag_d      = (mag_q >> 1) | (W'(digit_c) << (W - 1));
      sr_d       = sr_q >> 1;
      seen_one_d = seen_one_q | sr_q[0];
      count_d    = count_q + CW'(1);
      // No 1 in the low digits of a negative word means x = -2^(N-1).
      if (last_digit_c) begin
        ow_d = sign_q & ~(seen_one_q | sr_q[0]);
      end
    end
  end

  // Datapath registers
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      sr_q       <= '0;
      mag_q      <= '0;
      count_q    <= '0;
      sign_q     <= 1'b0;
      seen_one_q <= 1'b0;
      ow_q       <= 1'b0;
    end else begin
      sr_q       <= sr_d;
      mag_q      <= mag_d;
      count_q    <= count_d;
      sign_q     <= sign_d;
      seen_one_q <= seen_one_d;
      ow_q       <= ow_d;
    end
  end

  assign sign = sign_q;
  assign mag  = mag_q;
  assign ow   = ow_q;

endmodule

// File: tb/tb_c2_sm_serial_decoder.sv
// Directed bench for c2_sm_serial_decoder at N=8 and N=2, checked against
// an arithmetic model of sign-magnitude conversion and handshake timing.
module tb_c2_sm_serial_decoder;

  logic       clock = 1'b0;
  logic       reset;
  logic       in_valid, out_ready, in_ready, out_valid, sign, ow;
  logic [7:0] x;
  logic [6:0] mag;

  logic       in_valid2, out_ready2, in_ready2, out_valid2, sign2, ow2;
  logic [1:0] x2;
  logic [0:0] mag2;

  int vectors     = 0;
  int miscompares = 0;

  always #5 clock = ~clock;

  c2_sm_serial_decoder #(.N(8)) dut8 (
    .clock(clock), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
    .x(x), .out_valid(out_valid), .out_ready(out_ready),
    .sign(sign), .mag(mag), .ow(ow)
  );

  c2_sm_serial_decoder #(.N(2)) dut2 (
    .clock(clock), .reset(reset), .in_valid(in_valid2), .in_ready(in_ready2),
    .x(x2), .out_valid(out_valid2), .out_ready(out_ready2),
    .sign(sign2), .mag(mag2), .ow(ow2)
  );

  task automatic chk(input string nm, input int act, input int exp);
    vectors++;
    if (act != exp) begin
      miscompares++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  // Reference: {ow, sign, mag} from the numeric value of an n-digit word.
  function automatic logic [8:0] expect_res(input logic [7:0] xv, input int n);
    int full, low, s, m, o;
    full = int'(xv) % (1 << n);
    s    = (full >> (n - 1)) & 1;
    low  = full % (1 << (n - 1));
    m    = s ? (((1 << n) - full) % (1 << (n - 1))) : low;
    o    = (s == 1 && low == 0) ? 1 : 0;
    return {1'(o), 1'(s), 7'(m)};
  endfunction

  // Cycle-level model: busy from accept until consumed; result due N-1 edges after accept.
  logic       busy8, busy2;
  int         age8, age2;
  logic [8:0] exp8, exp2;

  always @(posedge clock or posedge reset) begin
    if (reset) begin
      busy8 <= 1'b0; age8 <= 0;
    end else if (!busy8) begin
      if (in_valid) begin busy8 <= 1'b1; age8 <= 0; exp8 <= expect_res(x, 8); end
    end else if (age8 < 7) begin
      age8 <= age8 + 1;
    end else if (out_ready) begin
      busy8 <= 1'b0;
    end
  end

  always @(posedge clock or posedge reset) begin
    if (reset) begin
      busy2 <= 1'b0; age2 <= 0;
    end else if (!busy2) begin
      if (in_valid2) begin busy2 <= 1'b1; age2 <= 0; exp2 <= expect_res({6'd0, x2}, 2); end
    end else if (age2 < 1) begin
      age2 <= age2 + 1;
    end else if (out_ready2) begin
      busy2 <= 1'b0;
    end
  end

  // Per-cycle comparison against the model
  always @(negedge clock) begin
    if (reset) begin
      chk("rst_in_ready", in_ready, 1);
      chk("rst_out_valid", out_valid, 0);
      chk("rst_sign", sign, 0);
      chk("rst_mag", mag, 0);
      chk("rst_ow", ow, 0);
      chk("rst_in_ready2", in_ready2, 1);
      chk("rst_out_valid2", out_valid2, 0);
    end else begin
      chk("m8_in_ready", in_ready, !busy8);
      chk("m8_out_valid", out_valid, busy8 && age8 == 7);
      if (busy8 && age8 == 7) begin
        chk("m8_sign", sign, exp8[7]);
        chk("m8_mag", mag, exp8[6:0]);
        chk("m8_ow", ow, exp8[8]);
      end
      chk("m2_in_ready", in_ready2, !busy2);
      chk("m2_out_valid", out_valid2, busy2 && age2 == 1);
      if (busy2 && age2 == 1) begin
        chk("m2_sign", sign2, exp2[7]);
        chk("m2_mag", mag2, exp2[0]);
        chk("m2_ow", ow2, exp2[8]);
      end
    end
  end

  // One N=8 word: accept, latency, literal result, optional backpressure, release.
  task automatic word8(input logic [7:0] xv, input int hold,
                       input logic es, input logic [6:0] em, input logic eo);
    int edges;
    chk("pre_in_ready", in_ready, 1);
    out_ready = (hold == 0);
    in_valid  = 1'b1;
    x         = xv;
    @(posedge clock); #1;
    in_valid = 1'b0;
    x        = 8'($urandom);
    edges    = 0;
    while (!out_valid && edges < 20) begin
      chk("busy_in_ready", in_ready, 0);
      @(posedge clock); #1;
      edges++;
    end
    chk("latency", edges, 7);
    chk("lit_sign", sign, es);
    chk("lit_mag", mag, em);
    chk("lit_ow", ow, eo);
    for (int i = 0; i < hold; i++) begin
      in_valid = ~in_valid;
      x        = 8'($urandom);
      @(posedge clock); #1;
      chk("hold_out_valid", out_valid, 1);
      chk("hold_in_ready", in_ready, 0);
      chk("hold_sign", sign, es);
      chk("hold_mag", mag, em);
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    @(posedge clock); #1;
    chk("rel_out_valid", out_valid, 0);
    chk("rel_in_ready", in_ready, 1);
  endtask

  initial begin
    logic [1:0] s2 [4];
    logic [0:0] m2 [4];
    logic [1:0] o2 [4];
    reset = 1'b1; in_valid = 1'b0; out_ready = 1'b1; x = 8'h00;
    in_valid2 = 1'b0; out_ready2 = 1'b1; x2 = 2'b00;
    #12 reset = 1'b0;
    @(posedge clock); #1;

    word8(8'h05, 0, 1'b0, 7'h05, 1'b0);
    word8(8'hFB, 0, 1'b1, 7'h05, 1'b0);
    word8(8'hFF, 0, 1'b1, 7'h01, 1'b0);
    word8(8'h00, 0, 1'b0, 7'h00, 1'b0);
    word8(8'h80, 0, 1'b1, 7'h00, 1'b1);
    word8(8'h81, 0, 1'b1, 7'h7F, 1'b0);
    word8(8'hF0, 3, 1'b1, 7'h10, 1'b0);

    // Abort mid-SHIFT with an asynchronous reset
    in_valid = 1'b1; x = 8'hC3;
    @(posedge clock); #1;
    in_valid = 1'b0;
    repeat (3) @(posedge clock);
    #1 reset = 1'b1;
    #1;
    chk("abort_in_ready", in_ready, 1);
    chk("abort_out_valid", out_valid, 0);
    chk("abort_mag", mag, 0);
    chk("abort_sign", sign, 0);
    chk("abort_ow", ow, 0);
    @(posedge clock); #2 reset = 1'b0;
    @(posedge clock); #1;
    word8(8'h3C, 0, 1'b0, 7'h3C, 1'b0);

    // N=2 boundary stream, back-to-back
    s2[0] = 2'd0; m2[0] = 1'b0; o2[0] = 2'd0;
    s2[1] = 2'd0; m2[1] = 1'b1; o2[1] = 2'd0;
    s2[2] = 2'd1; m2[2] = 1'b0; o2[2] = 2'd1;
    s2[3] = 2'd1; m2[3] = 1'b1; o2[3] = 2'd0;
    for (int v = 0; v < 4; v++) begin
      chk("n2_pre_in_ready", in_ready2, 1);
      in_valid2 = 1'b1;
      x2 = 2'(v);
      @(posedge clock); #1;
      in_valid2 = 1'b0;
      chk("n2_acc_in_ready", in_ready2, 0);
      @(posedge clock); #1;
      chk("n2_out_valid", out_valid2, 1);
      chk("n2_sign", sign2, s2[v][0]);
      chk("n2_mag", mag2, m2[v]);
      chk("n2_ow", ow2, o2[v][0]);
      @(posedge clock); #1;
      chk("n2_rel_out_valid", out_valid2, 0);
    end

    repeat (2) @(posedge clock);
    #1;
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/c2_sm_serial_decoder.md
# c2_sm_serial_decoder

Bit-serial converter from an N-digit two's complement word to sign-magnitude form (sign, N-1-digit magnitude, overflow flag). It is the decoding end of the two's complement negation path: it recovers |x| from a c2 operand using the "copy up to the first 1, then invert" rule, one digit per clock. It sits between an operand source and a sign-magnitude consumer, with a valid/ready handshake on both sides.

## Interface

- N, default 8, number of digits of the two's complement input; legal range N >= 2.
- clock  input  1  single system clock; all state updates on the rising edge.
- reset  input  1  asynchronous, active-high reset.
- in_valid  input  1  the source presents a word on x.
- in_ready  output  1  the block can accept a word; high only in IDLE.
- x  input  N  two's complement operand; sampled on the accept edge only.
- out_valid  output  1  sign, mag and ow hold a completed result.
- out_ready  input  1  the consumer takes the result.
- sign  output  1  sign of x (x[N-1]).
- mag  output  N-1  magnitude of x, modulo 2^(N-1).
- ow  output  1  overflow: high when x = -2^(N-1), which has no N-1-digit magnitude.

## Operation

- States: IDLE, SHIFT, DONE. in_ready = (state == IDLE). out_valid = (state == DONE). Both are decoded from registered state.
- Accept: when in_valid & in_ready are high at a rising edge:
  - load shift register sr <= x[N-2:0];
  - sign <= x[N-1]; seen_one <= 0; count <= 0;
  - go to SHIFT.
- SHIFT, one edge per digit, LSB first. Let b = sr[0]:
  - output digit d = sign & seen_one ? ~b : b;
  - shift d into the result register from the MSB side, so the digits land in mag[N-2:0] after N-1 shifts;
  - seen_one <= seen_one | b; sr <= sr >> 1; count <= count + 1;
  - on the edge that processes the digit where count = N-2, go to DONE.
- Positive input (sign = 0): mag = x[N-2:0] unchanged.
- Negative input: mag = (2^N - x) mod 2^(N-1).
- ow is registered on entry to DONE as sign & ~seen_one_final, which is equivalent to sign & (x[N-2:0] == 0). For x = -2^(N-1), mag = 0 and ow = 1. Otherwise ow = 0.
- DONE: sign, mag and ow stay stable until out_valid & out_ready at a rising edge. Then go to IDLE.
- in_valid is ignored outside IDLE. x is not required to stay stable after the accept edge.
- The block never accepts and delivers in the same cycle. There is no bypass or overlap; throughput is one word per N+1 cycles at best.

## Timing

- Reset (asynchronous, immediate):
  - state = IDLE, so in_ready = 1 and out_valid = 0;
  - sign = 0, mag = 0, ow = 0;
  - sr, count and seen_one are cleared.
- Reset asserted mid-SHIFT or in DONE aborts the word without delivering it. The first accept is possible on the first rising edge after reset deasserts.
- Latency:
  - accept edge at cycle 0;
  - out_valid rises after edge N-1 (N-1 SHIFT edges);
  - for N = 8, out_valid is high during cycle 7.
- Release:
  - consumer handshake at edge k: out_valid = 0 and in_ready = 1 in cycle k;
  - the next accept is possible at edge k+1;
  - with out_ready held high, the word period is N+1 cycles.
- Outputs are registered; there is no combinational path from in_valid, x or out_ready to any output.
- Count width is ceil(log2(N)), minimum 1.

## Test plan

- N=8, x=0x05, out_ready=1 -> out_valid high 7 cycles after accept; sign=0, mag=0x05, ow=0; in_ready low throughout SHIFT/DONE.
- N=8, x=0xFB (-5) -> sign=1, mag=0x05, ow=0. Also check x=0xFF -> sign=1, mag=0x01, ow=0 and x=0x00 -> sign=0, mag=0x00, ow=0.
- N=8, x=0x80 (-128) -> sign=1, mag=0x00, ow=1; next word x=0x81 -> sign=1, mag=0x7F, ow=0.
- Backpressure: x=0xF0, hold out_ready=0 for 3 cycles after out_valid, toggling in_valid and x -> sign=1, mag=0x10 held stable, in_ready=0; after the handshake, in_ready=1 in the following cycle.
- Reset mid-operation: accept x=0xC3, assert reset asynchronously after 3 SHIFT edges -> immediately in_ready=1, out_valid=0, mag=0, sign=0, ow=0; then x=0x3C -> mag=0x3C, sign=0 with the normal 7-cycle latency.
- Boundary width N=2: stream 00, 01, 10, 11 back-to-back with out_ready=1 -> (sign, mag, ow) = (0,0,0), (0,1,0), (1,0,1), (1,1,0); each result arrives 1 cycle after accept, and accepts are spaced 3 cycles apart.
